// File: rtl/emif_axil_bridge_if.sv
// AXI4-Lite channel bundle between the EMIF bridge (master) and the fabric (slave).
// 32-bit data and addresses; aresetn travels with the bus.
interface emif_axil_bridge_if;
    logic        aresetn;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output aresetn, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  aresetn, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/emif_axil_bridge.sv
// EMIF slave to AXI4-Lite master bridge: EMIF strobes queue commands in a FIFO that an FSM
// replays as single AXI-Lite transactions; read data returns through a FWFT FIFO.
module emif_axil_bridge #(
    parameter logic [23:0] EMIF_ADDR_BASE  = 24'h000000,
    parameter logic [31:0] AXIL_ADDR_BASE  = 32'h0,
    parameter int          AXIL_ADDR_WIDTH = 16,
    parameter int          CMD_DEPTH       = 16,
    parameter int          RD_DEPTH        = 16,
    parameter int          TIMEOUT         = 1023
) (
    input  logic        eclk,
    input  logic        rst,
    input  logic        nce,
    input  logic        noe,
    input  logic        nwe,
    input  logic [23:0] emif_addr,
    input  logic [31:0] emif_din,
    output logic [31:0] emif_dout,
    output logic        emif_doe,
    output logic        full,
    output logic        busy,
    output logic        rd_fifo_empty,
    output logic        err,
    output logic [1:0]  err_code,
    input  logic        err_clr,
    emif_axil_bridge_if.master m_axil
);
    localparam int WA    = AXIL_ADDR_WIDTH - 2;
    localparam int CMD_W = 1 + WA + 32;
    localparam int CAW   = $clog2(CMD_DEPTH);
    localparam int RAW   = $clog2(RD_DEPTH);
    localparam logic [23:0] WIN_MASK = 24'((64'd1 << (AXIL_ADDR_WIDTH - 1)) - 64'd1);
    localparam logic [CAW:0] CMD_FULL = (CAW + 1)'(CMD_DEPTH);
    localparam logic [RAW:0] RD_FULL  = (RAW + 1)'(RD_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_AR, S_R} state_t;

    // Pin capture; strobe registers idle high so reset never fakes a falling edge.
    logic        wstb_reg, wstb_prev_reg, rstb_reg, rstb_prev_reg;
    logic [23:0] addr_reg;
    logic [31:0] din_reg;

    always_ff @(posedge eclk) begin
        if (rst) begin
            wstb_reg      <= 1'b1;
            wstb_prev_reg <= 1'b1;
            rstb_reg      <= 1'b1;
            rstb_prev_reg <= 1'b1;
            addr_reg      <= '0;
            din_reg       <= '0;
        end else begin
            wstb_reg      <= nce | nwe;
            wstb_prev_reg <= wstb_reg;
            rstb_reg      <= nce | noe;
            rstb_prev_reg <= rstb_reg;
            addr_reg      <= emif_addr;
            din_reg       <= emif_din;
        end
    end

    logic hit_reg, hit_now, rflag;
    assign hit_reg  = ((addr_reg ^ EMIF_ADDR_BASE) & ~WIN_MASK) == 24'd0;
    assign hit_now  = ((emif_addr ^ EMIF_ADDR_BASE) & ~WIN_MASK) == 24'd0;
    assign rflag    = addr_reg[AXIL_ADDR_WIDTH-2];
    assign emif_doe = hit_now & ~nce & ~noe;

    // Command FIFO
    logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
    logic [CAW-1:0]   cmd_wp_reg, cmd_rp_reg;
    logic [CAW:0]     cmd_cnt_reg;
    logic             cmd_push_req, cmd_push, cmd_pop, cmd_empty, cmd_full, overflow;
    logic [CMD_W-1:0] cmd_head;

    assign cmd_empty    = cmd_cnt_reg == '0;
    assign cmd_full     = cmd_cnt_reg == CMD_FULL;
    assign cmd_push_req = wstb_prev_reg & ~wstb_reg & hit_reg;
    assign cmd_push     = cmd_push_req & (~cmd_full | cmd_pop);
    assign overflow     = cmd_push_req & cmd_full & ~cmd_pop;
    assign cmd_head     = cmd_mem[cmd_rp_reg];

    always_ff @(posedge eclk) begin
        if (cmd_push)
            cmd_mem[cmd_wp_reg] <= {rflag, addr_reg[WA-1:0], din_reg};
    end

    always_ff @(posedge eclk) begin
        if (rst) begin
            cmd_wp_reg  <= '0;
            cmd_rp_reg  <= '0;
            cmd_cnt_reg <= '0;
        end else begin
            if (cmd_push) cmd_wp_reg <= cmd_wp_reg + 1'b1;
            if (cmd_pop)  cmd_rp_reg <= cmd_rp_reg + 1'b1;
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt_reg <= cmd_cnt_reg + 1'b1;
                2'b01:   cmd_cnt_reg <= cmd_cnt_reg - 1'b1;
                default: cmd_cnt_reg <= cmd_cnt_reg;
            endcase
        end
    end

    // Read-data FIFO, first-word-fall-through towards the EMIF pins
    logic [31:0]  rd_mem [RD_DEPTH];
    logic [RAW-1:0] rd_wp_reg, rd_rp_reg;
    logic [RAW:0] rd_cnt_reg;
    logic         rd_push, rd_pop, rd_empty, rd_full;
    logic [31:0]  rd_push_data;

    assign rd_empty      = rd_cnt_reg == '0;
    assign rd_full       = rd_cnt_reg == RD_FULL;
    assign rd_pop        = rstb_prev_reg & ~rstb_reg & hit_reg & ~rd_empty;
    assign rd_fifo_empty = rd_empty;
    assign emif_dout     = rd_empty ? 32'h0 : rd_mem[rd_rp_reg];

    always_ff @(posedge eclk) begin
        if (rd_push)
            rd_mem[rd_wp_reg] <= rd_push_data;
    end

    always_ff @(posedge eclk) begin
        if (rst) begin
            rd_wp_reg  <= '0;
            rd_rp_reg  <= '0;
            rd_cnt_reg <= '0;
        end else begin
            if (rd_push) rd_wp_reg <= rd_wp_reg + 1'b1;
            if (rd_pop)  rd_rp_reg <= rd_rp_reg + 1'b1;
            case ({rd_push, rd_pop})
                2'b10:   rd_cnt_reg <= rd_cnt_reg + 1'b1;
                2'b01:   rd_cnt_reg <= rd_cnt_reg - 1'b1;
                default: rd_cnt_reg <= rd_cnt_reg;
            endcase
        end
    end

    // Transaction FSM
    state_t        state_reg, state_next;
    logic          aw_done_reg, aw_done_next, w_done_reg, w_done_next;
    logic [31:0]   tmo_cnt_reg, tmo_next;
    logic [WA-1:0] cur_addr_reg;
    logic [31:0]   cur_data_reg;
    logic          tmo_hit, resp_err, tmo_err;

    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_reg == 32'(TIMEOUT - 1));

    always_ff @(posedge eclk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            tmo_cnt_reg  <= '0;
            cur_addr_reg <= '0;
            cur_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            tmo_cnt_reg <= tmo_next;
            if (cmd_pop) begin
                cur_addr_reg <= cmd_head[CMD_W-2:32];
                cur_data_reg <= cmd_head[31:0];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        tmo_next     = tmo_cnt_reg;
        cmd_pop      = 1'b0;
        rd_push      = 1'b0;
        rd_push_data = 32'h0;
        resp_err     = 1'b0;
        tmo_err      = 1'b0;
        case (state_reg)
            S_IDLE: if (!cmd_empty) begin
                cmd_pop      = 1'b1;
                aw_done_next = 1'b0;
                w_done_next  = 1'b0;
                state_next   = cmd_head[CMD_W-1] ? S_AR : S_WR;
            end
            S_WR: begin
                if (m_axil.awready) aw_done_next = 1'b1;
                if (m_axil.wready)  w_done_next  = 1'b1;
                if (aw_done_next && w_done_next) state_next = S_WB;
            end
            S_WB: begin
                if (m_axil.bvalid) begin
                    resp_err   = m_axil.bresp != 2'b00;
                    state_next = S_IDLE;
                end else if (tmo_hit) begin
                    tmo_err    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    tmo_next = tmo_cnt_reg + 1'b1;
                end
            end
            S_AR: if (m_axil.arready) state_next = S_R;
            S_R: if (!rd_full) begin
                if (m_axil.rvalid) begin
                    rd_push      = 1'b1;
                    rd_push_data = m_axil.rdata;
                    resp_err     = m_axil.rresp != 2'b00;
                    state_next   = S_IDLE;
                end else if (tmo_hit) begin
                    // Substitute word keeps EMIF read count aligned with requests.
                    rd_push      = 1'b1;
                    rd_push_data = 32'hDEAD_BEEF;
                    tmo_err      = 1'b1;
                    state_next   = S_IDLE;
                end else begin
                    tmo_next = tmo_cnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (state_next != state_reg) tmo_next = '0;
    end

    // Sticky error: first code wins until cleared; a new error beats a clear.
    logic       err_set;
    logic [1:0] set_code;
    assign err_set  = overflow | resp_err | tmo_err;
    assign set_code = overflow ? 2'b01 : (resp_err ? 2'b10 : 2'b11);

    always_ff @(posedge eclk) begin
        if (rst) begin
            err      <= 1'b0;
            err_code <= 2'b00;
        end else if (err_set) begin
            err <= 1'b1;
            if (!err || err_clr) err_code <= set_code;
        end else if (err_clr) begin
            err      <= 1'b0;
            err_code <= 2'b00;
        end
    end

    assign full = cmd_full;
    assign busy = ~cmd_empty | (state_reg != S_IDLE);

    assign m_axil.aresetn = ~rst;
    assign m_axil.awaddr  = AXIL_ADDR_BASE + 32'({cur_addr_reg, 2'b00});
    assign m_axil.araddr  = AXIL_ADDR_BASE + 32'({cur_addr_reg, 2'b00});
    assign m_axil.awprot  = 3'b000;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.wdata   = cur_data_reg;
    assign m_axil.wstrb   = 4'hF;
    assign m_axil.awvalid = (state_reg == S_WR) & ~aw_done_reg;
    assign m_axil.wvalid  = (state_reg == S_WR) & ~w_done_reg;
    assign m_axil.bready  = state_reg == S_WB;
    assign m_axil.arvalid = state_reg == S_AR;
    assign m_axil.rready  = (state_reg == S_R) & ~rd_full;
endmodule

// File: tb/tb_emif_axil_bridge.sv
// Directed bench for emif_axil_bridge: a small AXI-Lite responder with knobs, and
// EMIF pin tasks driving writes, read-requests and reads through the bridge.
module tb_emif_axil_bridge;
    logic        eclk = 1'b0;
    logic        rst = 1'b1, nce = 1'b1, noe = 1'b1, nwe = 1'b1, err_clr = 1'b0;
    logic [23:0] emif_addr = '0;
    logic [31:0] emif_din = '0;
    logic [31:0] emif_dout;
    logic        emif_doe, full, busy, rd_fifo_empty, err;
    logic [1:0]  err_code;

    emif_axil_bridge_if axil ();

    always #5 eclk = ~eclk;

    emif_axil_bridge #(.TIMEOUT(15)) dut (
        .eclk(eclk), .rst(rst), .nce(nce), .noe(noe), .nwe(nwe),
        .emif_addr(emif_addr), .emif_din(emif_din), .emif_dout(emif_dout),
        .emif_doe(emif_doe), .full(full), .busy(busy), .rd_fifo_empty(rd_fifo_empty),
        .err(err), .err_code(err_code), .err_clr(err_clr), .m_axil(axil)
    );

    // Responder knobs and state
    logic        aw_rdy = 1'b1, w_rdy = 1'b1, ar_rdy = 1'b1, b_en = 1'b1, r_en = 1'b1;
    logic [1:0]  b_resp_v = 2'b00, r_resp_v = 2'b00;
    logic [31:0] r_data_v = '0;
    logic        bvalid_q = 1'b0, rvalid_q = 1'b0, r_pend_q = 1'b0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;

    assign axil.awready = aw_rdy;
    assign axil.wready  = w_rdy;
    assign axil.arready = ar_rdy;
    assign axil.bvalid  = bvalid_q;
    assign axil.bresp   = b_resp_v;
    assign axil.rvalid  = rvalid_q;
    assign axil.rdata   = r_data_v;
    assign axil.rresp   = r_resp_v;

    always @(posedge eclk) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            r_pend_q <= 1'b0;
        end else begin
            if (bvalid_q && axil.bready) bvalid_q <= 1'b0;
            else if (b_en && axil.bready) bvalid_q <= 1'b1;
            if (rvalid_q && axil.rready) begin
                rvalid_q <= 1'b0;
                r_pend_q <= 1'b0;
            end else if (axil.arvalid && ar_rdy) r_pend_q <= 1'b1;
            else if (r_pend_q && r_en) rvalid_q <= 1'b1;
            if (axil.awvalid && axil.awready) begin aw_cnt <= aw_cnt + 1; last_awaddr <= axil.awaddr; end
            if (axil.wvalid && axil.wready)   begin w_cnt <= w_cnt + 1;   last_wdata  <= axil.wdata;  end
            if (axil.arvalid && axil.arready) begin ar_cnt <= ar_cnt + 1; last_araddr <= axil.araddr; end
        end
    end

    int n_chk = 0, n_fail = 0, r_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge eclk);
        #1;
    endtask

    task automatic emif_write(input logic [23:0] a, input logic [31:0] d);
        emif_addr = a; emif_din = d; nce = 1'b0; nwe = 1'b0;
        step(); step();
        nce = 1'b1; nwe = 1'b1;
        step();
    endtask

    task automatic emif_read(input logic [23:0] a, output logic [31:0] d, output logic oe);
        emif_addr = a; nce = 1'b0; noe = 1'b0;
        step();
        d = emif_dout; oe = emif_doe;
        step();
        nce = 1'b1; noe = 1'b1;
        step();
    endtask

    // Waits for busy to drop; also counts cycles with RREADY high.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        r_cycles = (axil.rready === 1'b1) ? 1 : 0;
        while (busy !== 1'b0 && n < 300) begin
            step();
            n++;
            if (axil.rready === 1'b1) r_cycles++;
        end
        chk({tag, " idle"}, {31'b0, busy === 1'b0}, 32'd1);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_aw, base_ar;
        logic [31:0] d;
        logic oe;

        repeat (3) step();
        chk("rst full", full, 0);
        chk("rst busy", busy, 0);
        chk("rst rd_empty", rd_fifo_empty, 1);
        chk("rst err", {err, err_code}, 0);
        chk("rst valids", {axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready}, 0);
        chk("rst aresetn", axil.aresetn, 0);
        chk("rst dout", emif_dout, 0);
        rst = 1'b0;
        step();
        chk("aresetn high", axil.aresetn, 1);

        // Write with exact push/valid timing and independent AW/W completion
        aw_rdy = 1'b0; w_rdy = 1'b0;
        emif_addr = 24'h000010; emif_din = 32'h12345678; nce = 1'b0; nwe = 1'b0;
        step();
        chk("wr edge k busy", busy, 0);
        step();
        chk("wr edge k+1 busy", busy, 1);
        chk("wr edge k+1 awvalid", axil.awvalid, 0);
        step();
        chk("wr edge k+2 valids", {axil.awvalid, axil.wvalid}, 2'b11);
        chk("wr awaddr", axil.awaddr, 32'h40);
        chk("wr wdata", axil.wdata, 32'h12345678);
        chk("wr wstrb/prot", {axil.wstrb, axil.awprot}, 7'b1111_000);
        nce = 1'b1; nwe = 1'b1;
        aw_rdy = 1'b1;
        step();
        chk("wr aw done w pending", {axil.awvalid, axil.wvalid}, 2'b01);
        w_rdy = 1'b1;
        wait_idle("wr");
        chk("wr aw count", aw_cnt, 1);
        chk("wr w count", w_cnt, 1);
        chk("wr last wdata", last_wdata, 32'h12345678);
        chk("wr err", {err, err_code}, 0);

        // nwe held low for 8 cycles yields one command
        base_aw = aw_cnt;
        emif_addr = 24'h000020; emif_din = 32'hA5A5A5A5; nce = 1'b0; nwe = 1'b0;
        repeat (8) step();
        nce = 1'b1; nwe = 1'b1;
        step();
        wait_idle("hold");
        chk("hold one cmd", aw_cnt - base_aw, 1);
        chk("hold awaddr", last_awaddr, 32'h80);

        // Overflow: one write stuck in the FSM, then 17 more pulses
        base_aw = aw_cnt;
        aw_rdy = 1'b0;
        emif_write(24'h000100, 32'h100);
        for (int i = 1; i <= 16; i++) emif_write(24'h000100 + 24'(i), 32'h100 + 32'(i));
        chk("ovf full at 16", full, 1);
        chk("ovf no err yet", err, 0);
        emif_write(24'h000111, 32'h111);
        chk("ovf full stays", full, 1);
        chk("ovf err", {err, err_code}, 3'b1_01);
        aw_rdy = 1'b1;
        wait_idle("ovf drain");
        chk("ovf drained count", aw_cnt - base_aw, 17);
        chk("ovf last wdata", last_wdata, 32'h110);
        chk("ovf full cleared", full, 0);
        clear_err();
        chk("ovf err cleared", {err, err_code}, 0);

        // Read-request then EMIF read
        base_aw = aw_cnt; base_ar = ar_cnt;
        r_data_v = 32'hCAFEF00D;
        emif_write(24'h004004, 32'hFFFFFFFF);
        wait_idle("rd");
        chk("rd ar count", ar_cnt - base_ar, 1);
        chk("rd no write", aw_cnt - base_aw, 0);
        chk("rd araddr", last_araddr, 32'h10);
        chk("rd fifo filled", rd_fifo_empty, 0);
        chk("rd err", {err, err_code}, 0);
        emif_read(24'h000000, d, oe);
        chk("rd dout", d, 32'hCAFEF00D);
        chk("rd doe", oe, 1);
        chk("rd fifo empty after", rd_fifo_empty, 1);
        chk("rd doe released", emif_doe, 0);
        emif_read(24'h000000, d, oe);
        chk("rd empty dout", d, 0);
        chk("rd empty no err", {err, rd_fifo_empty}, 2'b01);

        // Bad responses
        b_resp_v = 2'b10;
        emif_write(24'h000030, 32'h3);
        wait_idle("slverr");
        chk("slverr code", {err, err_code}, 3'b1_10);
        b_resp_v = 2'b00;
        clear_err();
        chk("slverr cleared", {err, err_code}, 0);
        r_resp_v = 2'b11; r_data_v = 32'h0BADF00D;
        emif_write(24'h004010, 32'h0);
        wait_idle("decerr");
        chk("decerr code", {err, err_code}, 3'b1_10);
        chk("decerr araddr", last_araddr, 32'h40);
        emif_read(24'h000000, d, oe);
        chk("decerr data pushed", d, 32'h0BADF00D);
        r_resp_v = 2'b00;
        clear_err();

        // R timeout with no RVALID
        r_en = 1'b0;
        emif_write(24'h004008, 32'h0);
        wait_idle("tmo");
        chk("tmo cycles in R", r_cycles, 15);
        chk("tmo code", {err, err_code}, 3'b1_11);
        chk("tmo araddr", last_araddr, 32'h20);
        emif_read(24'h000000, d, oe);
        chk("tmo filler word", d, 32'hDEADBEEF);
        b_resp_v = 2'b10;
        emif_write(24'h000040, 32'h4);
        wait_idle("sticky");
        chk("sticky first code", {err, err_code}, 3'b1_11);
        b_resp_v = 2'b00;

        // Reset during WR
        aw_rdy = 1'b0;
        emif_write(24'h000050, 32'h5555);
        for (int n = 0; n < 30 && axil.awvalid !== 1'b1; n++) step();
        chk("midwr awvalid", axil.awvalid, 1);
        rst = 1'b1;
        step();
        chk("midwr valids dropped", {axil.awvalid, axil.wvalid}, 0);
        chk("midwr busy", busy, 0);
        chk("midwr err reset", {err, err_code}, 0);
        rst = 1'b0;
        aw_rdy = 1'b1; r_en = 1'b1;
        step();
        chk("post rst idle", {busy, axil.awvalid, axil.aresetn}, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
